// File: rtl/display_lcd_driver.sv
// display_lcd_driver: continuously refreshes a 16-column HD44780-class LCD
// (8-bit, write-only) from a snapshot of the flat DisplayBuffer bus.
// Optional build macro DISP_CHAR_FILTER_EN: when defined, character bytes
// outside 0x20..0x7E are sent as a space; command bytes are never touched.
//
// main state | meaning
// -----------+---------------------------------------------------------
// S_POWERUP  | idle with reset-valued outputs for PowerUpCycles
// S_INIT     | send 0x38, 0x0C, 0x01, 0x06
// S_SNAP     | one cycle: capture DisplayBuffer into the snapshot
// S_ADDR     | send DDRAM address command (0x80 line 0, 0xC0 line 1)
// S_CHARS    | send 16 characters of the current line
// S_GAP      | idle RefreshGapCycles between frames
//
// xfer state | meaning
// -----------+---------------------------------------------------------
// X_SETUP    | one cycle, rs/data driven, e low
// X_PULSE    | EPulseCycles with e high
// X_HOLD     | e low for the command/clear wait time
module display_lcd_driver #(
    parameter int DisplayBufferSize = 256,
    parameter int PowerUpCycles     = 2000000,
    parameter int EPulseCycles      = 25,
    parameter int CmdWaitCycles     = 2500,
    parameter int ClearWaitCycles   = 100000,
    parameter int RefreshGapCycles  = 500000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DisplayBufferSize-1:0] DisplayBuffer,
    output logic                         lcd_rs,
    output logic                         lcd_e,
    output logic [7:0]                   lcd_data,
    output logic                         init_done,
    output logic                         frame_strobe
);

    localparam int NBytes = DisplayBufferSize / 8;
    localparam int NLines = NBytes / 16;
    localparam int KW     = $clog2(NBytes);
    localparam int MaxA   = (PowerUpCycles > EPulseCycles) ? PowerUpCycles : EPulseCycles;
    localparam int MaxB   = (CmdWaitCycles > ClearWaitCycles) ? CmdWaitCycles : ClearWaitCycles;
    localparam int MaxC   = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int MaxCyc = (MaxC > RefreshGapCycles) ? MaxC : RefreshGapCycles;
    localparam int CW     = $clog2(MaxCyc + 1);

    typedef enum logic [2:0] {S_POWERUP, S_INIT, S_SNAP, S_ADDR, S_CHARS, S_GAP} main_t;
    typedef enum logic [1:0] {X_SETUP, X_PULSE, X_HOLD} xfer_t;

    main_t          main_q;
    xfer_t          xfer_q;
    logic [CW-1:0]  cnt_q;
    logic [1:0]     init_idx_q;
    logic           line_q;
    logic [3:0]     col_q;
    logic [7:0]     snap_q [NBytes];
    logic [7:0]     buf_bytes [NBytes];
    logic           lcd_rs_q, lcd_e_q, init_done_q, frame_strobe_q;
    logic [7:0]     lcd_data_q;

    logic [3:0]     next_col_d;
    logic [7:0]     char_d;
    logic [CW-1:0]  wait_d;

    // Byte 0 is the most significant byte of the bus.
    for (genvar g = 0; g < NBytes; g++) begin : g_unpack
        assign buf_bytes[g] = DisplayBuffer[(NBytes-g)*8-1 -: 8];
    end

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    function automatic logic [7:0] char_filter(input logic [7:0] b);
`ifdef DISP_CHAR_FILTER_EN
        return (b < 8'h20 || b > 8'h7E) ? 8'h20 : b;
`else
        return b;
`endif
    endfunction

    // Next character to load and the hold time of the byte now on the bus.
    always_comb begin
        next_col_d = (main_q == S_CHARS) ? col_q + 4'd1 : col_q;
        char_d     = char_filter(snap_q[KW'({line_q, next_col_d})]);
        wait_d     = (!lcd_rs_q && lcd_data_q == 8'h01) ? CW'(ClearWaitCycles - 1)
                                                        : CW'(CmdWaitCycles - 1);
    end

    // Sequencer and transfer engine; all pin outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_q         <= S_POWERUP;
            xfer_q         <= X_SETUP;
            cnt_q          <= CW'(PowerUpCycles - 1);
            init_idx_q     <= 2'd0;
            line_q         <= 1'b0;
            col_q          <= 4'd0;
            lcd_rs_q       <= 1'b0;
            lcd_e_q        <= 1'b0;
            lcd_data_q     <= 8'h00;
            init_done_q    <= 1'b0;
            frame_strobe_q <= 1'b0;
        end else begin
            frame_strobe_q <= 1'b0;
            case (main_q)
                S_POWERUP: begin
                    if (cnt_q == '0) begin
                        main_q     <= S_INIT;
                        xfer_q     <= X_SETUP;
                        init_idx_q <= 2'd0;
                        lcd_rs_q   <= 1'b0;
                        lcd_data_q <= init_cmd(2'd0);
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_SNAP: begin
                    snap_q     <= buf_bytes;
                    main_q     <= S_ADDR;
                    xfer_q     <= X_SETUP;
                    line_q     <= 1'b0;
                    col_q      <= 4'd0;
                    lcd_rs_q   <= 1'b0;
                    lcd_data_q <= 8'h80;
                end
                S_GAP: begin
                    if (cnt_q == '0) main_q <= S_SNAP;
                    else             cnt_q  <= cnt_q - CW'(1);
                end
                default: begin
                    case (xfer_q)
                        X_SETUP: begin
                            xfer_q  <= X_PULSE;
                            lcd_e_q <= 1'b1;
                            cnt_q   <= CW'(EPulseCycles - 1);
                        end
                        X_PULSE: begin
                            if (cnt_q == '0) begin
                                xfer_q  <= X_HOLD;
                                lcd_e_q <= 1'b0;
                                cnt_q   <= wait_d;
                            end else begin
                                cnt_q <= cnt_q - CW'(1);
                            end
                        end
                        X_HOLD: begin
                            if (cnt_q != '0) begin
                                cnt_q <= cnt_q - CW'(1);
                            end else begin
                                xfer_q <= X_SETUP;
                                case (main_q)
                                    S_INIT: begin
                                        if (init_idx_q == 2'd3) begin
                                            main_q      <= S_SNAP;
                                            init_done_q <= 1'b1;
                                        end else begin
                                            init_idx_q <= init_idx_q + 2'd1;
                                            lcd_data_q <= init_cmd(init_idx_q + 2'd1);
                                        end
                                    end
                                    S_ADDR: begin
                                        main_q     <= S_CHARS;
                                        lcd_rs_q   <= 1'b1;
                                        lcd_data_q <= char_d;
                                    end
                                    S_CHARS: begin
                                        if (col_q != 4'd15) begin
                                            col_q      <= next_col_d;
                                            lcd_data_q <= char_d;
                                        end else if (int'(line_q) < NLines - 1) begin
                                            main_q     <= S_ADDR;
                                            line_q     <= 1'b1;
                                            col_q      <= 4'd0;
                                            lcd_rs_q   <= 1'b0;
                                            lcd_data_q <= 8'hC0;
                                        end else begin
                                            main_q         <= S_GAP;
                                            col_q          <= 4'd0;
                                            frame_strobe_q <= 1'b1;
                                            cnt_q          <= CW'(RefreshGapCycles - 1);
                                        end
                                    end
                                    default: main_q <= S_POWERUP;
                                endcase
                            end
                        end
                        default: xfer_q <= X_SETUP;
                    endcase
                end
            endcase
        end
    end

    assign lcd_rs       = lcd_rs_q;
    assign lcd_e        = lcd_e_q;
    assign lcd_data     = lcd_data_q;
    assign init_done    = init_done_q;
    assign frame_strobe = frame_strobe_q;

endmodule

// File: tb/tb_display_lcd_driver.sv
// Testbench for display_lcd_driver: a 2-line and a 1-line instance share the
// same buffer (the 1-line one sees bytes 0..15). A timeline model predicts
// the rise cycle, rs and data of every byte plus init_done/frame_strobe
// cycles; monitors pop and compare as the DUTs produce them.
module tb_display_lcd_driver;

    localparam int P    = 10;
    localparam int E    = 2;
    localparam int CMDW = 3;
    localparam int CLR  = 20;
    localparam int G    = 5;

    typedef struct {
        int         t;
        logic       rs;
        logic [7:0] d;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [255:0] buf_drv = '0;
    logic         rs0, e0, id0, fs0, rs1, e1, id1, fs1;
    logic [7:0]   d0, d1;

    int   cyc;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t qb0[$], qb1[$];
    int   qf0[$], qf1[$], qi0[$], qi1[$];
    bit   done[2];
    logic pe[2], pid[2];
    int   rt[2];
    logic [8:0] rv[2];

    display_lcd_driver #(
        .DisplayBufferSize(256), .PowerUpCycles(P), .EPulseCycles(E),
        .CmdWaitCycles(CMDW), .ClearWaitCycles(CLR), .RefreshGapCycles(G)
    ) dut (
        .clk(clk), .reset(reset), .DisplayBuffer(buf_drv),
        .lcd_rs(rs0), .lcd_e(e0), .lcd_data(d0),
        .init_done(id0), .frame_strobe(fs0)
    );

    display_lcd_driver #(
        .DisplayBufferSize(128), .PowerUpCycles(P), .EPulseCycles(E),
        .CmdWaitCycles(CMDW), .ClearWaitCycles(CLR), .RefreshGapCycles(G)
    ) dut128 (
        .clk(clk), .reset(reset), .DisplayBuffer(buf_drv[255:128]),
        .lcd_rs(rs1), .lcd_e(e1), .lcd_data(d1),
        .init_done(id1), .frame_strobe(fs1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void bad(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endfunction

    function automatic logic [7:0] model_char(input logic [7:0] b);
`ifdef DISP_CHAR_FILTER_EN
        if (b < 8'h20 || b > 8'h7E) return 8'h20;
`endif
        return b;
    endfunction

    function automatic logic [7:0] byte_of(input logic [255:0] b, input int k);
        logic [255:0] s;
        s = b >> ((31 - k) * 8);
        return s[7:0];
    endfunction

    task automatic set_byte(input int k, input logic [7:0] v);
        buf_drv[(32-k)*8-1 -: 8] = v;
    endtask

    task automatic push_b(input int sel, input int t, input logic rs, input logic [7:0] d);
        exp_t x;
        x.t = t; x.rs = rs; x.d = d;
        if (sel == 0) qb0.push_back(x);
        else          qb1.push_back(x);
    endtask

    // Reference timeline: byte rises are spaced 1+E+wait, SNAP adds one
    // cycle and the gap adds G; each frame uses the buffer seen at SNAP.
    task automatic run_model(input int sel, input int frames);
        int           t;
        int           lines;
        logic [255:0] snap;
        logic [7:0]   cmds [4];
        cmds = '{8'h38, 8'h0C, 8'h01, 8'h06};
        t = P + 1;
        for (int i = 0; i < 4; i++) begin
            push_b(sel, t, 1'b0, cmds[i]);
            t += 1 + E + ((cmds[i] == 8'h01) ? CLR : CMDW);
        end
        if (sel == 0) qi0.push_back(t - 1);
        else          qi1.push_back(t - 1);
        t += 1;
        lines = (sel == 0) ? 2 : 1;
        for (int f = 0; f < frames; f++) begin
            wait (cyc >= t - 1);
            #1;
            snap = buf_drv;
            for (int l = 0; l < lines; l++) begin
                push_b(sel, t, 1'b0, (l == 0) ? 8'h80 : 8'hC0);
                t += 1 + E + CMDW;
                for (int c = 0; c < 16; c++) begin
                    push_b(sel, t, 1'b1, model_char(byte_of(snap, 16 * l + c)));
                    t += 1 + E + CMDW;
                end
            end
            if (sel == 0) qf0.push_back(t - 1);
            else          qf1.push_back(t - 1);
            t += G + 1;
        end
        done[sel] = 1'b1;
    endtask

    task automatic mon_step(input int sel, input logic e, input logic rs, input logic [7:0] d,
                            input logic fs, input logic id);
        exp_t  x;
        string nm;
        bit    have;
        nm = (sel == 0) ? "dut256" : "dut128";
        if (e && !pe[sel]) begin
            rt[sel] = cyc;
            rv[sel] = {rs, d};
            have = (sel == 0) ? (qb0.size() > 0) : (qb1.size() > 0);
            if (have) begin
                if (sel == 0) x = qb0.pop_front();
                else          x = qb1.pop_front();
                chk({nm, " byte rise cycle"}, cyc, x.t);
                chk({nm, " byte rs"}, int'(rs), int'(x.rs));
                chk({nm, " byte data"}, int'(d), int'(x.d));
            end else if (!done[sel]) begin
                bad({nm, " unexpected byte"});
            end
        end
        if (!e && pe[sel] && cyc > rt[sel]) begin
            chk({nm, " e pulse width"}, cyc - rt[sel], E);
            chk({nm, " rs/data stable"}, int'({rs, d}), int'(rv[sel]));
        end
        pe[sel] = e;
        if (fs === 1'b1) begin
            have = (sel == 0) ? (qf0.size() > 0) : (qf1.size() > 0);
            if (have) chk({nm, " frame_strobe cycle"}, cyc, (sel == 0) ? qf0.pop_front() : qf1.pop_front());
            else if (!done[sel]) bad({nm, " unexpected frame_strobe"});
        end
        if (id === 1'b1 && pid[sel] !== 1'b1) begin
            have = (sel == 0) ? (qi0.size() > 0) : (qi1.size() > 0);
            if (have) chk({nm, " init_done rise cycle"}, cyc, (sel == 0) ? qi0.pop_front() : qi1.pop_front());
            else bad({nm, " unexpected init_done rise"});
        end
        pid[sel] = id;
    endtask

    initial begin
        pe  = '{1'b0, 1'b0};
        pid = '{1'b0, 1'b0};
        rt  = '{0, 0};
        forever begin
            @(negedge clk);
            mon_step(0, e0, rs0, d0, fs0, id0);
            mon_step(1, e1, rs1, d1, fs1, id1);
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((qb0.size() + qb1.size() + qf0.size() + qf1.size() + qi0.size() + qi1.size()) > 0
               && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) bad("scoreboard drain timeout");
    endtask

    task automatic flush();
        qb0.delete(); qb1.delete(); qf0.delete(); qf1.delete(); qi0.delete(); qi1.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " lcd_e"}, int'(e0), 0);
        chk({tag, " lcd_rs"}, int'(rs0), 0);
        chk({tag, " lcd_data"}, int'(d0), 0);
        chk({tag, " init_done"}, int'(id0), 0);
        chk({tag, " frame_strobe"}, int'(fs0), 0);
        chk({tag, " dut128 lcd_e"}, int'(e1), 0);
        chk({tag, " dut128 init_done"}, int'(id1), 0);
    endtask

    initial begin
        bit found;
        done = '{1'b1, 1'b1};
        set_byte(0, 8'h48); set_byte(1, 8'h45); set_byte(2, 8'h4C);
        set_byte(3, 8'h4C); set_byte(4, 8'h4F);
        for (int k = 5; k < 32; k++) set_byte(k, 8'h41);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Phase 1: power-up, init, HELLO frames, byte 0 changed mid-frame.
        done = '{1'b0, 1'b0};
        reset = 1'b0;
        fork
            run_model(0, 3);
            run_model(1, 5);
            begin
                wait (cyc >= 200);
                @(negedge clk);
                set_byte(0, 8'h4A);
                wait (cyc >= 420);
                @(negedge clk);
                for (int k = 5; k < 32; k++) set_byte(k, 8'($urandom_range(0, 255)));
            end
        join
        drain();

        // Phase 2: one-cycle reset while e is high during a character.
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (e0 && rs0) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) bad("no character strobe seen before mid-transfer reset");
        reset = 1'b1;
        flush();
        @(negedge clk);
        check_reset_outputs("mid-transfer reset");
        for (int k = 0; k < 32; k++) set_byte(k, 8'($urandom_range(0, 255)));
        set_byte(3, 8'h07);
        set_byte(4, 8'hFF);
        done = '{1'b0, 1'b0};
        reset = 1'b0;

        // Phase 3: full restart with control/high bytes in line 0.
        fork
            run_model(0, 2);
            run_model(1, 3);
            begin
                wait (cyc >= 150);
                @(negedge clk);
                for (int k = 0; k < 16; k++)
                    if (k != 3 && k != 4) set_byte(k, 8'($urandom_range(0, 255)));
            end
        join
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
